// File: rtl/ahb_timer_pkg.sv
// Shared definitions for the AHB timer: bus encodings, register map, control bits and
// the data-phase state type used by the AHB3-Lite slave front end.
package ahb_timer_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [4:0] OFF_CTRL        = 5'h00;
    localparam logic [4:0] OFF_PRESCALE    = 5'h04;
    localparam logic [4:0] OFF_MTIME_LO    = 5'h08;
    localparam logic [4:0] OFF_MTIME_HI    = 5'h0C;
    localparam logic [4:0] OFF_MTIMECMP_LO = 5'h10;
    localparam logic [4:0] OFF_MTIMECMP_HI = 5'h14;
    localparam logic [4:0] OFF_STATUS      = 5'h18;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {StIdle, StData, StErr1, StErr2} dp_state_e;

    function automatic logic htrans_active(input logic [1:0] htrans);
        logic act;
        act = 1'b0;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/ahb3lite_slave_frontend.sv
// AHB3-Lite slave front end: address-phase capture, error decode and the data-phase FSM
// producing zero-wait OKAY or the two-cycle ERROR response.
module ahb3lite_slave_frontend
    import ahb_timer_pkg::*;
#(
    parameter int unsigned HADDR_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hsel_i,
    input  logic                  hwrite_i,
    input  logic                  hready_i,
    input  logic [2:0]            hsize_i,
    input  logic [2:0]            hburst_i,
    input  logic [1:0]            htrans_i,
    input  logic [HADDR_SIZE-1:0] haddr_i,
    output logic                  wr_en_o,
    output logic                  rd_en_o,
    output logic [4:0]            offset_o,
    output logic                  hreadyout_o,
    output logic                  hresp_o
);

    dp_state_e   state_q, state_d;
    logic        write_q, write_d;
    logic [4:0]  offset_q, offset_d;
    logic [4:0]  offset_in;
    logic        accept;
    logic        addr_err;
    logic        unused_bits;

    // Bursts are handled beat by beat and only the low five address bits are decoded.
    assign unused_bits = ^{hburst_i, haddr_i[HADDR_SIZE-1:5]};

    always_comb begin
        offset_in   = haddr_i[4:0];
        addr_err    = (hsize_i != HSIZE_WORD) || (offset_in[1:0] != 2'b00) ||
                      (offset_in > OFF_STATUS) || (hwrite_i && offset_in == OFF_STATUS);
        // During ERR1 the slave is stalling the bus, so no new address phase completes.
        accept      = hsel_i && hready_i && htrans_active(htrans_i) && (state_q != StErr1);
        state_d     = StIdle;
        write_d     = write_q;
        offset_d    = offset_q;
        hreadyout_o = 1'b1;
        hresp_o     = 1'b0;
        unique case (state_q)
            StIdle: ;
            StData: ;
            StErr1: begin
                state_d     = StErr2;
                hreadyout_o = 1'b0;
                hresp_o     = 1'b1;
            end
            StErr2: hresp_o = 1'b1;
        endcase
        if (accept) begin
            write_d  = hwrite_i;
            offset_d = offset_in;
            state_d  = addr_err ? StErr1 : StData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            write_q  <= 1'b0;
            offset_q <= 5'h00;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            offset_q <= offset_d;
        end
    end

    assign wr_en_o  = (state_q == StData) && write_q;
    assign rd_en_o  = (state_q == StData) && !write_q;
    assign offset_o = offset_q;

endmodule

// File: rtl/ahb_timer.sv
// AHB3-Lite timer peripheral: 64-bit mtime/mtimecmp with prescaler, coherent high-word
// shadow for split reads, and a registered level interrupt while mtime >= mtimecmp.
module ahb_timer
    import ahb_timer_pkg::*;
#(
    parameter int unsigned HADDR_SIZE = 32,
    parameter int unsigned HDATA_SIZE = 32,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hsel_i,
    input  logic                  hwrite_i,
    input  logic                  hready_i,
    input  logic [2:0]            hsize_i,
    input  logic [2:0]            hburst_i,
    input  logic [1:0]            htrans_i,
    input  logic [HDATA_SIZE-1:0] hwdata_i,
    input  logic [HADDR_SIZE-1:0] haddr_i,
    output logic                  hreadyout_o,
    output logic                  hresp_o,
    output logic [HDATA_SIZE-1:0] hrdata_o,
    output logic                  timer_irq_o
);

    localparam logic [PRESCALE_W-1:0] CntOne = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic                  wr_en, rd_en;
    logic [4:0]            offset;
    logic [1:0]            ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           mtimecmp_q, mtimecmp_d;
    logic [31:0]           hi_shadow_q, hi_shadow_d;
    logic                  irq_q, irq_d;
    logic                  tick;
    logic                  cmp_hit;
    logic [HDATA_SIZE-1:0] rdata;

    ahb3lite_slave_frontend #(
        .HADDR_SIZE (HADDR_SIZE)
    ) u_frontend (
        .clk         (clk),
        .rst_n       (rst_n),
        .hsel_i      (hsel_i),
        .hwrite_i    (hwrite_i),
        .hready_i    (hready_i),
        .hsize_i     (hsize_i),
        .hburst_i    (hburst_i),
        .htrans_i    (htrans_i),
        .haddr_i     (haddr_i),
        .wr_en_o     (wr_en),
        .rd_en_o     (rd_en),
        .offset_o    (offset),
        .hreadyout_o (hreadyout_o),
        .hresp_o     (hresp_o)
    );

    always_comb begin
        ctrl_d      = ctrl_q;
        prescale_d  = prescale_q;
        cnt_d       = cnt_q;
        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        hi_shadow_d = hi_shadow_q;
        cmp_hit     = (mtime_q >= mtimecmp_q);
        irq_d       = ctrl_q[CTRL_IRQ_EN] && cmp_hit;
        tick        = ctrl_q[CTRL_EN] && (cnt_q == prescale_q);

        if (ctrl_q[CTRL_EN]) begin
            cnt_d = tick ? '0 : cnt_q + CntOne;
        end
        if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        // A bus write to either mtime half overrides the tick in the same cycle.
        if (wr_en) begin
            unique case (offset)
                OFF_CTRL: begin
                    ctrl_d = hwdata_i[1:0];
                    cnt_d  = '0;
                end
                OFF_PRESCALE: begin
                    prescale_d = hwdata_i[PRESCALE_W-1:0];
                    cnt_d      = '0;
                end
                OFF_MTIME_LO:    mtime_d    = {mtime_q[63:32], hwdata_i[31:0]};
                OFF_MTIME_HI:    mtime_d    = {hwdata_i[31:0], mtime_q[31:0]};
                OFF_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], hwdata_i[31:0]};
                OFF_MTIMECMP_HI: mtimecmp_d = {hwdata_i[31:0], mtimecmp_q[31:0]};
                default: ;
            endcase
        end

        unique case (offset)
            OFF_CTRL:        rdata = {{(HDATA_SIZE-2){1'b0}}, ctrl_q};
            OFF_PRESCALE:    rdata = {{(HDATA_SIZE-PRESCALE_W){1'b0}}, prescale_q};
            OFF_MTIME_LO:    rdata = mtime_q[31:0];
            OFF_MTIME_HI:    rdata = hi_shadow_q;
            OFF_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
            OFF_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
            OFF_STATUS:      rdata = {{(HDATA_SIZE-1){1'b0}}, cmp_hit};
            default:         rdata = '0;
        endcase

        // Reading the low word freezes the high word so a LO-then-HI pair is coherent.
        if (rd_en && offset == OFF_MTIME_LO) begin
            hi_shadow_d = mtime_q[63:32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q      <= 2'b00;
            prescale_q  <= '0;
            cnt_q       <= '0;
            mtime_q     <= 64'h0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            hi_shadow_q <= 32'h0;
            irq_q       <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            prescale_q  <= prescale_d;
            cnt_q       <= cnt_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            hi_shadow_q <= hi_shadow_d;
            irq_q       <= irq_d;
        end
    end

    assign hrdata_o    = rd_en ? rdata : '0;
    assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_ahb_timer.sv
// Self-checking bench for ahb_timer: register table with a transfer scoreboard, then
// prescaler, carry/shadow, interrupt timing, error response and write-vs-tick sequences.
module tb_ahb_timer;
    import ahb_timer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel_i, hwrite_i, hready_i;
    logic [2:0]  hsize_i, hburst_i;
    logic [1:0]  htrans_i;
    logic [31:0] hwdata_i, haddr_i;
    logic        hreadyout_o, hresp_o, timer_irq_o;
    logic [31:0] hrdata_o;

    always #5 clk = ~clk;

    // Single-slave bus: HREADY follows this slave's HREADYOUT.
    assign hready_i = hreadyout_o;

    ahb_timer #(
        .HADDR_SIZE (32),
        .HDATA_SIZE (32),
        .PRESCALE_W (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hsel_i      (hsel_i),
        .hwrite_i    (hwrite_i),
        .hready_i    (hready_i),
        .hsize_i     (hsize_i),
        .hburst_i    (hburst_i),
        .htrans_i    (htrans_i),
        .hwdata_i    (hwdata_i),
        .haddr_i     (haddr_i),
        .hreadyout_o (hreadyout_o),
        .hresp_o     (hresp_o),
        .hrdata_o    (hrdata_o),
        .timer_irq_o (timer_irq_o)
    );

    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input string n, input logic wr, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] ex,
                                input logic err, input logic [2:0] sz = 3'b010);
        vec_t v;
        v.name = n; v.wr = wr; v.addr = a; v.size = sz;
        v.wdata = wd; v.exp = ex; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        hsel_i = 1'b0; htrans_i = HTRANS_IDLE; hwrite_i = 1'b0;
        haddr_i = 32'h0; hsize_i = HSIZE_WORD;
    endtask

    task automatic addr_phase(input vec_t v);
        hsel_i = 1'b1; htrans_i = HTRANS_NONSEQ; hwrite_i = v.wr;
        haddr_i = v.addr; hsize_i = v.size;
        sb.push_back(v);
    endtask

    // Called at the negedge inside a data phase; returns at the negedge after it ends.
    task automatic data_phase();
        vec_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        if (e.err) begin
            chk({e.name, "_err1_ready"}, hreadyout_o, 0);
            chk({e.name, "_err1_resp"}, hresp_o, 1);
            chk({e.name, "_err1_rdata"}, hrdata_o, 0);
            @(negedge clk);
            chk({e.name, "_err2_ready"}, hreadyout_o, 1);
            chk({e.name, "_err2_resp"}, hresp_o, 1);
        end else begin
            chk({e.name, "_ready"}, hreadyout_o, 1);
            chk({e.name, "_resp"}, hresp_o, 0);
            if (!e.wr) chk({e.name, "_rdata"}, hrdata_o, e.exp);
        end
        @(negedge clk);
    endtask

    task automatic xfer(input vec_t v);
        addr_phase(v);
        @(negedge clk);
        bus_idle();
        hwdata_i = v.wdata;
        data_phase();
    endtask

    task automatic wr(input string n, input logic [31:0] a, input logic [31:0] d);
        xfer(mk(n, 1'b1, a, d, 32'h0, 1'b0));
    endtask

    task automatic rd(input string n, input logic [31:0] a, input logic [31:0] ex);
        xfer(mk(n, 1'b0, a, 32'h0, ex, 1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; hburst_i = 3'b000; hwdata_i = 32'h0;
        bus_idle();
        repeat (3) @(negedge clk);
        chk("rst_hreadyout", hreadyout_o, 1);
        chk("rst_hresp", hresp_o, 0);
        chk("rst_hrdata", hrdata_o, 0);
        chk("rst_irq", timer_irq_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset values, register read/write, shadow behaviour and error responses.
        tbl.push_back(mk("rst_cmp_lo",  0, OFF_MTIMECMP_LO, 0, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk("rst_cmp_hi",  0, OFF_MTIMECMP_HI, 0, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk("rst_ctrl",    0, OFF_CTRL,        0, 32'h0, 0));
        tbl.push_back(mk("rst_presc",   0, OFF_PRESCALE,    0, 32'h0, 0));
        tbl.push_back(mk("rst_mt_lo",   0, OFF_MTIME_LO,    0, 32'h0, 0));
        tbl.push_back(mk("rst_mt_hi",   0, OFF_MTIME_HI,    0, 32'h0, 0));
        tbl.push_back(mk("rst_status",  0, OFF_STATUS,      0, 32'h0, 0));
        tbl.push_back(mk("w_presc",     1, OFF_PRESCALE,    32'hABCD_1234, 0, 0));
        tbl.push_back(mk("r_presc",     0, OFF_PRESCALE,    0, 32'h0000_1234, 0));
        tbl.push_back(mk("w_ctrl_hi",   1, OFF_CTRL,        32'hFFFF_FFFC, 0, 0));
        tbl.push_back(mk("r_ctrl_hi",   0, OFF_CTRL,        0, 32'h0, 0));
        tbl.push_back(mk("w_cmp_hi",    1, OFF_MTIMECMP_HI, 32'h1234_5678, 0, 0));
        tbl.push_back(mk("r_cmp_hi",    0, OFF_MTIMECMP_HI, 0, 32'h1234_5678, 0));
        tbl.push_back(mk("w_mt_hi",     1, OFF_MTIME_HI,    32'h0000_0007, 0, 0));
        tbl.push_back(mk("r_hi_stale",  0, OFF_MTIME_HI,    0, 32'h0, 0));
        tbl.push_back(mk("r_lo_snap",   0, OFF_MTIME_LO,    0, 32'h0, 0));
        tbl.push_back(mk("r_hi_fresh",  0, OFF_MTIME_HI,    0, 32'h0000_0007, 0));
        tbl.push_back(mk("r_status_0",  0, OFF_STATUS,      0, 32'h0, 0));
        tbl.push_back(mk("w_cmp_hi0",   1, OFF_MTIMECMP_HI, 32'h0, 0, 0));
        tbl.push_back(mk("r_status_1",  0, OFF_STATUS,      0, 32'h1, 0));
        tbl.push_back(mk("w_status",    1, OFF_STATUS,      32'h1, 0, 1));
        tbl.push_back(mk("r_misalign",  0, 32'h0000_0002,   0, 0, 1));
        tbl.push_back(mk("r_half",      0, OFF_CTRL,        0, 0, 1, 3'b001));
        tbl.push_back(mk("w_cmp_hi_ff", 1, OFF_MTIMECMP_HI, 32'hFFFF_FFFF, 0, 0));
        tbl.push_back(mk("w_mt_hi0",    1, OFF_MTIME_HI,    32'h0, 0, 0));
        tbl.push_back(mk("w_ctrl_irq",  1, OFF_CTRL,        32'h2, 0, 0));
        tbl.push_back(mk("w_ctrl_byte", 1, OFF_CTRL,        32'h1, 0, 1, 3'b000));
        tbl.push_back(mk("r_oob_1c",    0, 32'h0000_001C,   0, 0, 1));
        tbl.push_back(mk("r_ctrl_kept", 0, OFF_CTRL,        0, 32'h2, 0));
        tbl.push_back(mk("w_ctrl_off",  1, OFF_CTRL,        32'h0, 0, 0));
        foreach (tbl[i]) xfer(tbl[i]);
        chk("tbl_irq_low", timer_irq_o, 0);

        // Prescaler: one tick per 4 cycles counted from the enabling CTRL write.
        wr("p_presc3", OFF_PRESCALE, 32'h3);
        wr("p_en", OFF_CTRL, 32'h1);
        repeat (39) @(negedge clk);
        rd("p_mt_lo", OFF_MTIME_LO, 32'h0000_000A);
        rd("p_mt_hi", OFF_MTIME_HI, 32'h0);

        // Carry from LO into HI, and the shadowed HI read.
        wr("c_off", OFF_CTRL, 32'h0);
        wr("c_presc0", OFF_PRESCALE, 32'h0);
        wr("c_hi0", OFF_MTIME_HI, 32'h0);
        wr("c_lo", OFF_MTIME_LO, 32'hFFFF_FFFE);
        wr("c_en", OFF_CTRL, 32'h1);
        @(negedge clk);
        rd("c_mt_lo", OFF_MTIME_LO, 32'h0);
        rd("c_mt_hi", OFF_MTIME_HI, 32'h1);

        // Interrupt rises one cycle after mtime reaches mtimecmp.
        wr("i_off", OFF_CTRL, 32'h0);
        wr("i_lo0", OFF_MTIME_LO, 32'h0);
        wr("i_hi0", OFF_MTIME_HI, 32'h0);
        wr("i_cmp_hi", OFF_MTIMECMP_HI, 32'h0);
        wr("i_cmp_lo", OFF_MTIMECMP_LO, 32'h20);
        wr("i_en", OFF_CTRL, 32'h3);
        for (int t = 0; t <= 40; t++) begin
            chk($sformatf("irq_t%0d", t), timer_irq_o, (t >= 33) ? 1 : 0);
            @(negedge clk);
        end
        wr("i_cmp_far", OFF_MTIMECMP_LO, 32'hFFFF_FFFF);
        chk("irq_hold", timer_irq_o, 1);
        @(negedge clk);
        chk("irq_drop", timer_irq_o, 0);

        // Pipelined write then read of MTIME_LO while every cycle ticks.
        addr_phase(mk("b2b_wr", 1, OFF_MTIME_LO, 32'h55, 0, 0));
        @(negedge clk);
        hwdata_i = 32'h55;
        addr_phase(mk("b2b_rd", 0, OFF_MTIME_LO, 0, 32'h55, 0));
        data_phase();
        bus_idle();
        data_phase();

        // Reset in the middle of a data phase aborts the pending write.
        hsel_i = 1'b1; htrans_i = HTRANS_NONSEQ; hwrite_i = 1'b1;
        haddr_i = {27'h0, OFF_PRESCALE}; hsize_i = HSIZE_WORD;
        @(negedge clk);
        bus_idle();
        hwdata_i = 32'h77;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", hreadyout_o, 1);
        chk("mid_rst_irq", timer_irq_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd("mid_rst_presc", OFF_PRESCALE, 32'h0);
        rd("mid_rst_cmp", OFF_MTIMECMP_LO, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
